// File: rtl/bus_select_decoder_pkg.sv
// Shared CPU definitions for the bus select decoder: IR field positions,
// bus source codes and the drive-FSM state encoding.
package bus_select_decoder_pkg;

    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    localparam logic [4:0] CODE_HI     = 5'd16;
    localparam logic [4:0] CODE_LO     = 5'd17;
    localparam logic [4:0] CODE_ZHI    = 5'd18;
    localparam logic [4:0] CODE_ZLO    = 5'd19;
    localparam logic [4:0] CODE_PC     = 5'd20;
    localparam logic [4:0] CODE_MDR    = 5'd21;
    localparam logic [4:0] CODE_INPORT = 5'd22;
    localparam logic [4:0] CODE_C      = 5'd23;
    localparam logic [4:0] CODE_NONE   = 5'd31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/bus_select_decoder_if.sv
// Control-unit to bus-select-decoder signal bundle. The control unit is the
// master; the decoder is the slave.
interface bus_select_decoder_if;
    import bus_select_decoder_pkg::*;

    logic [31:0] ir_in;
    logic        ir_load;
    logic        gra;
    logic        grb;
    logic        grc;
    logic        rout;
    logic        rin;
    logic        ba_out;
    logic        src_valid;
    logic [4:0]  src_code;

    logic [31:0] out_en;
    logic [15:0] in_en;
    logic [4:0]  code_echo;
    logic        busy;
    logic        err;

    modport master (
        output ir_in, ir_load, gra, grb, grc, rout, rin, ba_out, src_valid, src_code,
        input  out_en, in_en, code_echo, busy, err
    );

    modport slave (
        input  ir_in, ir_load, gra, grb, grc, rout, rin, ba_out, src_valid, src_code,
        output out_en, in_en, code_echo, busy, err
    );

endinterface

// File: rtl/bus_select_decoder_decoder.sv
// Combinational 5-to-32 one-hot decoder; codes at or above NUM_SRC decode
// to all zeros so "no source" never enables a driver.
module decoder_5_32 #(
    parameter int NUM_SRC = 24
) (
    input  logic [4:0]  i_code,
    output logic [31:0] o_onehot
);

    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        o_onehot = '0;
        if (int'(i_code) < NUM_SRC) begin
            o_onehot[i_code] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_select_decoder.sv
// Turns register-select and direct source requests into registered one-hot
// bus drive and register load enables, with break-before-make on source change.
module bus_select_decoder
    import bus_select_decoder_pkg::*;
#(
    parameter int NUM_SRC    = 24,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 clear,
    bus_select_decoder_if.slave  bus
);

    localparam logic [7:0] GAP_INIT = 8'(GAP_CYCLES);

    logic [31:0] r_ir;
    state_t      r_state;
    logic [4:0]  r_cur;
    logic [7:0]  r_gap_cnt;
    logic [31:0] r_out_en;
    logic [15:0] r_in_en;
    logic [4:0]  r_code_echo;
    logic        r_busy;
    logic        r_err;

    logic [3:0]  w_idx;
    logic        w_idx_valid;
    logic        w_multi_gr;
    logic        w_no_gr_err;
    logic        w_src_bad;
    logic [4:0]  w_req;
    logic        w_req_valid;
    state_t      w_nxt_state;
    logic [4:0]  w_nxt_cur;
    logic [7:0]  w_nxt_gap_cnt;
    logic [4:0]  w_drive_code;
    logic [31:0] w_out_dec;
    logic [31:0] w_in_dec;
    logic        w_unused;

    assign w_unused = ^{r_ir[31:RA_MSB+1], r_ir[RC_LSB-1:0], w_in_dec[31:16]};

    // Field select always looks at the registered IR, so a same-cycle load is not seen.
    always_comb begin
        w_idx       = 4'd0;
        w_idx_valid = 1'b1;
        if (bus.gra) begin
            w_idx = r_ir[RA_MSB:RA_LSB];
        end else if (bus.grb) begin
            w_idx = r_ir[RB_MSB:RB_LSB];
        end else if (bus.grc) begin
            w_idx = r_ir[RC_MSB:RC_LSB];
        end else begin
            w_idx_valid = 1'b0;
        end
    end

    assign w_multi_gr  = (bus.gra & bus.grb) | (bus.gra & bus.grc) | (bus.grb & bus.grc);
    assign w_no_gr_err = (bus.rout | bus.ba_out | bus.rin) & ~w_idx_valid;

    always_comb begin
        w_req     = CODE_NONE;
        w_src_bad = 1'b0;
        if ((bus.rout || bus.ba_out) && w_idx_valid) begin
            // Base-address drive of R0 reads as zero on the bus: nobody drives.
            if (!(bus.ba_out && w_idx == 4'd0)) begin
                w_req = {1'b0, w_idx};
            end
        end else if (bus.src_valid) begin
            if (int'(bus.src_code) < NUM_SRC) begin
                w_req = bus.src_code;
            end else if (bus.src_code != CODE_NONE) begin
                w_src_bad = 1'b1;
            end
        end
    end

    assign w_req_valid = (w_req != CODE_NONE);

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_cur     = r_cur;
        w_nxt_gap_cnt = r_gap_cnt;
        case (r_state)
            IDLE: begin
                if (w_req_valid) begin
                    w_nxt_state = DRIVE;
                    w_nxt_cur   = w_req;
                end
            end
            DRIVE: begin
                if (!w_req_valid) begin
                    w_nxt_state = IDLE;
                end else if (w_req != r_cur) begin
                    w_nxt_state   = GAP;
                    w_nxt_gap_cnt = GAP_INIT;
                end
            end
            GAP: begin
                if (r_gap_cnt <= 8'd1) begin
                    if (w_req_valid) begin
                        w_nxt_state = DRIVE;
                        w_nxt_cur   = w_req;
                    end else begin
                        w_nxt_state = IDLE;
                    end
                end else begin
                    w_nxt_gap_cnt = r_gap_cnt - 8'd1;
                end
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    assign w_drive_code = (w_nxt_state == DRIVE) ? w_nxt_cur : CODE_NONE;

    decoder_5_32 #(.NUM_SRC(NUM_SRC)) u_out_dec (
        .i_code   (w_drive_code),
        .o_onehot (w_out_dec)
    );

    decoder_5_32 #(.NUM_SRC(NUM_SRC)) u_in_dec (
        .i_code   ({1'b0, w_idx}),
        .o_onehot (w_in_dec)
    );

    // Outputs are registered from next-state values so enables track the FSM exactly.
    always_ff @(posedge clock) begin
        if (clear) begin
            // NOTE: non-blocking for all sequential state; clear resets every register.
            r_ir        <= '0;
            r_state     <= IDLE;
            r_cur       <= CODE_NONE;
            r_gap_cnt   <= '0;
            r_out_en    <= '0;
            r_in_en     <= '0;
            r_code_echo <= CODE_NONE;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (bus.ir_load) begin
                r_ir <= bus.ir_in;
            end
            r_state     <= w_nxt_state;
            r_cur       <= w_nxt_cur;
            r_gap_cnt   <= w_nxt_gap_cnt;
            r_out_en    <= w_out_dec;
            r_code_echo <= w_drive_code;
            r_busy      <= (w_nxt_state == GAP);
            r_in_en     <= (bus.rin && w_idx_valid) ? w_in_dec[15:0] : 16'd0;
            if (w_multi_gr || w_no_gr_err || w_src_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.out_en    = r_out_en;
    assign bus.in_en     = r_in_en;
    assign bus.code_echo = r_code_echo;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_bus_select_decoder.sv
// Directed self-checking bench for bus_select_decoder with hand-computed
// expectations and a small bus-encoder model for the round-trip check.
module tb_bus_select_decoder;

    logic clock;
    logic clear;
    int   tests;
    int   fails;

    bus_select_decoder_if bus();

    bus_select_decoder #(.NUM_SRC(24), .GAP_CYCLES(1)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ir_in     = '0;
        bus.ir_load   = 1'b0;
        bus.gra       = 1'b0;
        bus.grb       = 1'b0;
        bus.grc       = 1'b0;
        bus.rout      = 1'b0;
        bus.rin       = 1'b0;
        bus.ba_out    = 1'b0;
        bus.src_valid = 1'b0;
        bus.src_code  = 5'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".out_en"},    bus.out_en, 32'h0);
        check({tag, ".in_en"},     32'(bus.in_en), 32'h0);
        check({tag, ".code_echo"}, 32'(bus.code_echo), 32'd31);
        check({tag, ".busy"},      32'(bus.busy), 32'd0);
        check({tag, ".err"},       32'(bus.err), 32'd0);
    endtask

    function automatic logic [4:0] encode(input logic [31:0] v);
        logic [4:0] c;
        c = 5'd31;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) c = 5'(i);
        end
        return c;
    endfunction

    logic [31:0] prev_out;
    logic [31:0] exp_oh;

    initial begin
        tests = 0;
        fails = 0;
        idle_inputs();
        clear = 1'b1;
        step();
        step();
        check_reset_outputs("reset");
        clear = 1'b0;

        // Load IR with Ra=2, Rb=9 and drive R2 for three cycles.
        bus.ir_in = 32'h0148_0000; bus.ir_load = 1'b1;
        step();
        bus.ir_load = 1'b0;
        bus.gra = 1'b1; bus.rout = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rout_r2.out_en", bus.out_en, 32'h0000_0004);
            check("rout_r2.code", 32'(bus.code_echo), 32'd2);
        end
        bus.gra = 1'b0; bus.rout = 1'b0;
        step();
        check("rout_r2_end.out_en", bus.out_en, 32'h0);
        check("rout_r2_end.code", 32'(bus.code_echo), 32'd31);

        // R2 then PC directly: one gap cycle.
        bus.gra = 1'b1; bus.rout = 1'b1;
        step();
        check("r2_pc.first", bus.out_en, 32'h0000_0004);
        bus.gra = 1'b0; bus.rout = 1'b0;
        bus.src_valid = 1'b1; bus.src_code = 5'd20;
        step();
        check("r2_pc.gap_out", bus.out_en, 32'h0);
        check("r2_pc.gap_busy", 32'(bus.busy), 32'd1);
        step();
        check("r2_pc.pc_out", bus.out_en, 32'h0010_0000);
        check("r2_pc.pc_code", 32'(bus.code_echo), 32'd20);
        check("r2_pc.pc_busy", 32'(bus.busy), 32'd0);
        bus.src_valid = 1'b0;
        step();

        // Single-cycle register load of R9.
        bus.grb = 1'b1; bus.rin = 1'b1;
        step();
        check("rin_r9.in_en", 32'(bus.in_en), 32'h0000_0200);
        check("rin_r9.out_en", bus.out_en, 32'h0);
        bus.grb = 1'b0; bus.rin = 1'b0;
        step();
        check("rin_r9.drop", 32'(bus.in_en), 32'h0);
        check("rin_r9.err", 32'(bus.err), 32'd0);

        // IR with Ra=0, Rb=9: ba_out on R0 drives nothing, on R9 drives bit 9.
        bus.ir_in = 32'h0048_0000; bus.ir_load = 1'b1;
        step();
        bus.ir_load = 1'b0;
        bus.ba_out = 1'b1; bus.gra = 1'b1;
        step();
        check("ba_r0.out_en", bus.out_en, 32'h0);
        check("ba_r0.code", 32'(bus.code_echo), 32'd31);
        check("ba_r0.err", 32'(bus.err), 32'd0);
        bus.gra = 1'b0; bus.grb = 1'b1;
        step();
        check("ba_r9.out_en", bus.out_en, 32'h0000_0200);
        check("ba_r9.code", 32'(bus.code_echo), 32'd9);
        bus.ba_out = 1'b0; bus.grb = 1'b0;
        bus.src_valid = 1'b1; bus.src_code = 5'd25;
        step();
        check("bad_code.out_en", bus.out_en, 32'h0);
        check("bad_code.err", 32'(bus.err), 32'd1);
        bus.src_valid = 1'b0;
        step();
        step();
        check("bad_code.err_held", 32'(bus.err), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("bad_code.err_clear", 32'(bus.err), 32'd0);

        // Multiple gr lines: Ra wins, err set; then clear in the middle of a gap.
        bus.ir_in = 32'h0148_0000; bus.ir_load = 1'b1;
        step();
        bus.ir_load = 1'b0;
        bus.gra = 1'b1; bus.grc = 1'b1; bus.rout = 1'b1;
        step();
        check("multi_gr.out_en", bus.out_en, 32'h0000_0004);
        check("multi_gr.err", 32'(bus.err), 32'd1);
        bus.gra = 1'b0; bus.grc = 1'b0; bus.rout = 1'b0;
        bus.src_valid = 1'b1; bus.src_code = 5'd21;
        step();
        check("mid_gap.busy", 32'(bus.busy), 32'd1);
        clear = 1'b1;
        step();
        check_reset_outputs("clear_gap");
        clear = 1'b0;
        step();
        check("after_clear.out_en", bus.out_en, 32'h0020_0000);
        check("after_clear.code", 32'(bus.code_echo), 32'd21);
        bus.src_valid = 1'b0;
        step();

        // IR was cleared; a same-cycle load is not visible to the decode.
        bus.ir_in = 32'h0148_0000; bus.ir_load = 1'b1;
        bus.gra = 1'b1; bus.rout = 1'b1;
        step();
        check("old_ir.out_en", bus.out_en, 32'h0000_0001);
        check("old_ir.code", 32'(bus.code_echo), 32'd0);
        bus.ir_load = 1'b0;
        step();
        check("new_ir.gap_busy", 32'(bus.busy), 32'd1);
        check("new_ir.gap_out", bus.out_en, 32'h0);
        step();
        check("new_ir.out_en", bus.out_en, 32'h0000_0004);
        bus.gra = 1'b0; bus.rout = 1'b0;
        step();

        // Round trip through an encoder model for every valid source code.
        clear = 1'b1;
        step();
        clear = 1'b0;
        prev_out = 32'h0;
        bus.src_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            bus.src_code = 5'(c);
            for (int s = 0; s < 3; s++) begin
                step();
                check("bbm", 32'((prev_out != 0) && (bus.out_en != 0) && (prev_out != bus.out_en)), 32'd0);
                check("onehot", 32'($countones(bus.out_en) <= 1), 32'd1);
                prev_out = bus.out_en;
            end
            exp_oh = 32'd1 << c;
            check("rt.out_en", bus.out_en, exp_oh);
            check("rt.code", 32'(bus.code_echo), 32'(c));
            check("rt.encode", 32'(encode(bus.out_en)), 32'(bus.code_echo));
        end
        bus.src_valid = 1'b0;
        step();
        check("rt_end.out_en", bus.out_en, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_select_decoder.md
# bus_select_decoder

Converts the control unit's bus-source and register-select requests into one-hot datapath enables. It is the inverse of the bus encoder: it turns a 5-bit source code into the 32-bit one-hot drive vector that the encoder folds back into the bus mux select. It latches IR, decodes the Ra/Rb/Rc fields, and registers all enables. When the driven source changes, it inserts a break-before-make gap so that two drivers are never enabled in the same cycle.

## Interface
- NUM_SRC, 24: valid source codes are 0..NUM_SRC-1; all other codes mean "no source".
- GAP_CYCLES, 1: number of dead cycles inserted between two different driven sources; minimum 1.
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  synchronous, active-high reset.
- ir_in  in  32  instruction word.
- ir_load  in  1  latch ir_in into the internal IR at the next edge.
- gra, grb, grc  in  1  select the IR field: Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
- rout, rin, ba_out  in  1  register drive / register load / base-address drive.
- src_valid  in  1  direct source request is present.
- src_code  in  5  direct source code (16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 INPORT, 23 C).
- out_en  out  32  one-hot bus drive enables; all zero means no driver.
- in_en  out  16  one-hot register load enables (R0..R15).
- code_echo  out  5  code currently being driven; 31 when none.
- busy  out  1  high during a gap.
- err  out  1  sticky request-error flag; cleared only by clear.

## Operation
- **IR latch.** The internal IR loads ir_in on ir_load. Field decode always uses the registered IR, so ir_load together with rout in the same cycle decodes the old IR.
- **Field select.** Priority is gra > grb > grc, giving a 4-bit index idx.
  - More than one gr* high sets err.
  - No gr* high while rout, ba_out or rin is high sets err and produces no register request.
- **Request code req, per cycle, in priority order:**
  - (rout | ba_out) with a valid idx gives req = idx. The exception is ba_out with idx=0, which gives req = none (the bus reads zero).
  - Otherwise, src_valid gives req = src_code.
  - Otherwise req = none.
  - A src_code in NUM_SRC..30 gives req = none and sets err. Code 31 gives none with no error.
- **FSM states: IDLE, DRIVE, GAP.** cur is the registered driven code.
  - IDLE: req valid → DRIVE with cur=req. req none → stay in IDLE.
  - DRIVE: req==cur → stay. req none → IDLE. req valid and different → GAP, with gap counter = GAP_CYCLES.
  - GAP: decrement the counter. When it expires, evaluate req at that cycle: valid → DRIVE with cur=req; none → IDLE. Request changes during the gap do not restart it.
- **Outputs by state.**
  - out_en = onehot(cur) in DRIVE, zero otherwise.
  - code_echo = cur in DRIVE, 31 otherwise.
  - busy = 1 only in GAP.
- **Register loads.** in_en is a registered single-cycle pulse, onehot(idx), for each cycle rin is high with a valid idx. It is not gapped. rin and rout in the same cycle on the same register are legal.
- **Clear** overrides everything: IR=0, state=IDLE, out_en=0, in_en=0, code_echo=31, busy=0, err=0.

## Timing
- Latency from request to out_en is 1 cycle from IDLE.
- A source change costs 1+GAP_CYCLES cycles: the old enable drops at edge N+1, and the new enable rises at edge N+1+GAP_CYCLES.
- in_en latency is 1 cycle; the pulse width equals the number of cycles rin is held.
- err sets on the edge after the offending cycle and holds.
- A clear asserted mid-DRIVE or mid-GAP zeroes every output at the next edge. The first request after clear is accepted with normal latency.
- out_en has at most one bit set in any cycle, and is never nonzero in the cycle immediately after a different nonzero value.

## Structure
- The shared CPU package holds:
  - the IR field bit positions;
  - the source code constants: CODE_HI..CODE_C = 16..23, CODE_NONE = 31;
  - the state enum: IDLE, DRIVE, GAP.
- decoder_5_32: a combinational one-hot decoder that outputs zero for codes ≥ NUM_SRC. It is instantiated twice: once for out_en (32-bit) and once for in_en (using the lower 16 bits).

## Test plan
- After clear, load IR=0x0148_0000 (Ra=2, Rb=9), then gra+rout for 3 cycles → out_en=0x0000_0004 from edge 1 to edge 3, code_echo=2, then 0 and 31.
- Rout R2 followed directly by src_valid with code 20 (PC) → one cycle of out_en=0 with busy=1, then out_en=0x0010_0000 and code_echo=20.
- grb+rin for 1 cycle with IR Rb=9 → a single-cycle in_en=0x0200, and out_en is unaffected.
- ba_out+gra with Ra=0 → out_en stays 0, code_echo=31, err=0. src_code=25 → out_en=0 and err=1 held until clear.
- gra and grc both high with rout → Ra is driven and err=1. Then clear asserted mid-GAP → all outputs at reset values on the next edge.
- Round-trip: feed out_en into the bus encoder for every code 0..23 → the encoder output equals code_echo.
